z80fi_insn_tracker: RTL and testbench

// - Upstream feeder for the z80fi_insn_spec_* checkers: observes core fetch/retire events, assembles opcode bytes, snapshots pre-execution state.
// - Emits one registered z80fi_valid pulse per retired instruction with z80fi_insn, z80fi_insn_len and *_rdata fields, all stable in that cycle.
// - Sits between core sequencer and the formal/spec checker layer.
//

---
 rtl/z80fi_insn_tracker.sv | 147 ++++++++++++++
 tb/tb_z80fi_insn_tracker.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/z80fi_insn_tracker.sv
// Assembles opcode bytes of each retiring Z80 instruction and emits one z80fi_valid pulse with a pre-execution state snapshot.
// Optional feature: define Z80FI_ORDER_EN to add the z80fi_order retirement counter output.
module z80fi_insn_tracker #(
  parameter int MAX_LEN     = 4,
  parameter int ORDER_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   insn_start,
  input  logic [15:0]            start_pc,
  input  logic [7:0]             start_r,
  input  logic [7:0]             start_f,
  input  logic                   start_iff2,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  input  logic                   insn_done,
  output logic                   z80fi_valid,
  output logic [31:0]            z80fi_insn,
  output logic [2:0]             z80fi_insn_len,
  output logic [15:0]            z80fi_pc_rdata,
  output logic [7:0]             z80fi_r_rdata,
  output logic [7:0]             z80fi_f_rdata,
  output logic                   z80fi_iff2_rdata,
`ifdef Z80FI_ORDER_EN
  output logic [ORDER_WIDTH-1:0] z80fi_order,
`endif
  output logic                   z80fi_error
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_buf;
  logic [2:0]  r_cnt;
  logic [15:0] r_pc;
  logic [7:0]  r_r, r_f;
  logic        r_iff2;

  logic [31:0] w_base_buf, w_nbuf, w_ret_buf;
  logic [2:0]  w_base_cnt, w_ncnt, w_ret_cnt;
  logic        w_app, w_retire, w_err;

  always_comb begin
    w_state_nxt = r_state;
    w_retire    = 1'b0;
    w_err       = 1'b0;
    // insn_start restarts collection, so a byte in the same cycle becomes byte 0 of the new instruction
    w_base_buf  = insn_start ? 32'h0 : r_buf;
    w_base_cnt  = insn_start ? 3'd0  : r_cnt;
    w_app       = byte_valid && (insn_start || r_state == COLLECT);
    w_nbuf      = w_base_buf;
    w_ncnt      = w_base_cnt;
    if (w_app) begin
      if (w_base_cnt == 3'(MAX_LEN)) begin
        w_err = 1'b1;
      end else begin
        w_nbuf[{w_base_cnt[1:0], 3'b000} +: 8] = byte_data;
        w_ncnt = w_base_cnt + 3'd1;
      end
    end
    w_ret_buf = insn_start ? r_buf : w_nbuf;
    w_ret_cnt = insn_start ? r_cnt : w_ncnt;
    case (r_state)
      IDLE: begin
        if (insn_start) w_state_nxt = COLLECT;
        if (insn_done || (byte_valid && !insn_start)) w_err = 1'b1;
      end
      COLLECT: begin
        if (insn_done) begin
          if (w_ret_cnt == 3'd0) w_err = 1'b1;
          else                   w_retire = 1'b1;
          w_state_nxt = insn_start ? COLLECT : IDLE;
        end else if (insn_start) begin
          w_err = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_r     <= '0;
      r_f     <= '0;
      r_iff2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt == IDLE) begin
        r_buf <= '0;
        r_cnt <= '0;
      end else begin
        r_buf <= w_nbuf;
        r_cnt <= w_ncnt;
      end
      if (insn_start) begin
        r_pc   <= start_pc;
        r_r    <= start_r;
        r_f    <= start_f;
        r_iff2 <= start_iff2;
      end
    end
  end

  // Output bank holds the last retired instruction while z80fi_valid is low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z80fi_valid      <= 1'b0;
      z80fi_insn       <= '0;
      z80fi_insn_len   <= '0;
      z80fi_pc_rdata   <= '0;
      z80fi_r_rdata    <= '0;
      z80fi_f_rdata    <= '0;
      z80fi_iff2_rdata <= 1'b0;
      z80fi_error      <= 1'b0;
    end else begin
      z80fi_valid <= w_retire;
      z80fi_error <= z80fi_error | w_err;
      if (w_retire) begin
        z80fi_insn       <= w_ret_buf;
        z80fi_insn_len   <= w_ret_cnt;
        z80fi_pc_rdata   <= r_pc;
        z80fi_r_rdata    <= r_r;
        z80fi_f_rdata    <= r_f;
        z80fi_iff2_rdata <= r_iff2;
      end
    end
  end

`ifdef Z80FI_ORDER_EN
  logic [ORDER_WIDTH-1:0] r_order_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_order_cnt <= '0;
      z80fi_order <= '0;
    end else if (w_retire) begin
      z80fi_order <= r_order_cnt;
      r_order_cnt <= r_order_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_z80fi_insn_tracker.sv
// Directed bench for z80fi_insn_tracker; define Z80FI_ORDER_EN to also exercise the retirement counter.
module tb_z80fi_insn_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        insn_start = 1'b0;
  logic [15:0] start_pc = '0;
  logic [7:0]  start_r = '0, start_f = '0;
  logic        start_iff2 = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        insn_done = 1'b0;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [15:0] z80fi_pc_rdata;
  logic [7:0]  z80fi_r_rdata, z80fi_f_rdata;
  logic        z80fi_iff2_rdata, z80fi_error;
`ifdef Z80FI_ORDER_EN
  logic [63:0] z80fi_order;
`endif

  int errors = 0;
  int checks = 0;

  z80fi_insn_tracker dut (
    .clk(clk), .reset(reset), .insn_start(insn_start), .start_pc(start_pc),
    .start_r(start_r), .start_f(start_f), .start_iff2(start_iff2),
    .byte_valid(byte_valid), .byte_data(byte_data), .insn_done(insn_done),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_r_rdata(z80fi_r_rdata),
    .z80fi_f_rdata(z80fi_f_rdata), .z80fi_iff2_rdata(z80fi_iff2_rdata),
`ifdef Z80FI_ORDER_EN
    .z80fi_order(z80fi_order),
`endif
    .z80fi_error(z80fi_error)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, then land 1ns after the capturing edge
  task automatic drv(input logic st, input logic [15:0] pc, input logic bv,
                     input logic [7:0] bd, input logic dn);
    insn_start = st; start_pc = pc; byte_valid = bv; byte_data = bd; insn_done = dn;
    @(posedge clk); #1;
    insn_start = 1'b0; byte_valid = 1'b0; insn_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got %h exp 0", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", z80fi_error); end
  endtask

  task automatic test_ld_a_r();
    start_r = 8'h85; start_f = 8'h29; start_iff2 = 1'b1;
    drv(1, 16'h1234, 0, 8'h00, 0);
    start_r = 8'h00; start_f = 8'h00; start_iff2 = 1'b0;
    drv(0, 16'h0, 1, 8'hED, 0);
    drv(0, 16'h0, 1, 8'h5F, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ldar_early_valid got %b exp 0", z80fi_valid); end
    drv(0, 16'h0, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ldar_valid got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h00005FED) begin errors++; $display("FAIL ldar_insn got %h exp 00005fed", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd2) begin errors++; $display("FAIL ldar_len got %0d exp 2", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h1234) begin errors++; $display("FAIL ldar_pc got %h exp 1234", z80fi_pc_rdata); end
    checks++; if (z80fi_r_rdata !== 8'h85) begin errors++; $display("FAIL ldar_r got %h exp 85", z80fi_r_rdata); end
    checks++; if (z80fi_f_rdata !== 8'h29) begin errors++; $display("FAIL ldar_f got %h exp 29", z80fi_f_rdata); end
    checks++; if (z80fi_iff2_rdata !== 1'b1) begin errors++; $display("FAIL ldar_iff2 got %b exp 1", z80fi_iff2_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL ldar_error got %b exp 0", z80fi_error); end
    drv(0, 16'h0, 0, 8'h00, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ldar_pulse_width got %b exp 0", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h00005FED) begin errors++; $display("FAIL ldar_hold got %h exp 00005fed", z80fi_insn); end
  endtask

  task automatic test_back_to_back();
    drv(1, 16'h0000, 1, 8'h00, 0);
    drv(1, 16'h0001, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL b2b_len1 got %0d exp 1", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0000) begin errors++; $display("FAIL b2b_pc1 got %h exp 0000", z80fi_pc_rdata); end
    checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL b2b_insn1 got %h exp 0", z80fi_insn); end
    drv(0, 16'h0, 1, 8'h3E, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", z80fi_valid); end
    drv(0, 16'h0, 1, 8'h07, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid2 got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0000073E) begin errors++; $display("FAIL b2b_insn2 got %h exp 0000073e", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd2) begin errors++; $display("FAIL b2b_len2 got %0d exp 2", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0001) begin errors++; $display("FAIL b2b_pc2 got %h exp 0001", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL b2b_error got %b exp 0", z80fi_error); end
  endtask

  task automatic test_reset_mid();
    drv(1, 16'h4000, 1, 8'hED, 0);
    reset = 1'b1;
    #1;
    checks++; if (z80fi_valid !== 1'b0 || z80fi_insn !== 32'h0) begin errors++; $display("FAIL rstmid_clear got valid=%b insn=%h exp 0/0", z80fi_valid, z80fi_insn); end
    @(posedge clk); #1;
    reset = 1'b0;
    drv(1, 16'h4100, 1, 8'h00, 0);
    drv(0, 16'h0, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL rstmid_insn got %h exp 0", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL rstmid_len got %0d exp 1", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h4100) begin errors++; $display("FAIL rstmid_pc got %h exp 4100", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL rstmid_error got %b exp 0", z80fi_error); end
  endtask

  task automatic test_overflow();
    logic [7:0] bytes [5] = '{8'hDD, 8'hCB, 8'h05, 8'h46, 8'hFF};
    drv(1, 16'h0100, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) drv(0, 16'h0, 1, bytes[i], 0);
    drv(0, 16'h0, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h4605CBDD) begin errors++; $display("FAIL ovf_insn got %h exp 4605cbdd", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL ovf_len got %0d exp 4", z80fi_insn_len); end
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL ovf_error got %b exp 1", z80fi_error); end
  endtask

  task automatic test_empty_retire();
    do_reset();
    drv(1, 16'h0200, 0, 8'h00, 0);
    drv(0, 16'h0, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", z80fi_valid); end
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL empty_error got %b exp 1", z80fi_error); end
    drv(1, 16'h0300, 1, 8'h00, 0);
    drv(0, 16'h0, 1, 8'hC9, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL empty_next_valid got %b exp 1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0000C900) begin errors++; $display("FAIL empty_next_insn got %h exp 0000c900", z80fi_insn); end
    checks++; if (z80fi_pc_rdata !== 16'h0300) begin errors++; $display("FAIL empty_next_pc got %h exp 0300", z80fi_pc_rdata); end
  endtask

  task automatic test_abandon();
    do_reset();
    drv(1, 16'h0050, 1, 8'h11, 0);
    drv(1, 16'h0055, 1, 8'h22, 0);
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL abandon_error got %b exp 1", z80fi_error); end
    drv(0, 16'h0, 0, 8'h00, 1);
    checks++; if (z80fi_valid !== 1'b1 || z80fi_insn !== 32'h22) begin errors++; $display("FAIL abandon_insn got valid=%b insn=%h exp 1/00000022", z80fi_valid, z80fi_insn); end
    checks++; if (z80fi_pc_rdata !== 16'h0055) begin errors++; $display("FAIL abandon_pc got %h exp 0055", z80fi_pc_rdata); end
  endtask

  task automatic test_idle_stray();
    do_reset();
    drv(0, 16'h0, 1, 8'hAA, 0);
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL stray_error got %b exp 1", z80fi_error); end
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL stray_valid got %b exp 0", z80fi_valid); end
  endtask

`ifdef Z80FI_ORDER_EN
  task automatic test_order();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drv(1, 16'(i), 1, 8'h00, 0);
      drv(0, 16'h0, 0, 8'h00, 1);
      checks++; if (z80fi_valid !== 1'b1 || z80fi_order !== 64'(i)) begin errors++; $display("FAIL order_%0d got valid=%b order=%0d exp 1/%0d", i, z80fi_valid, z80fi_order, i); end
    end
    do_reset();
    checks++; if (z80fi_order !== 64'd0) begin errors++; $display("FAIL order_reset got %0d exp 0", z80fi_order); end
  endtask
`endif

  initial begin
    test_reset();
    test_ld_a_r();
    test_back_to_back();
    test_reset_mid();
    test_overflow();
    test_empty_retire();
    test_abandon();
    test_idle_stray();
`ifdef Z80FI_ORDER_EN
    test_order();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
